// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles, branch flush,
// data-memory wait freeze with resume, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W           = 4,
  parameter int LU_STALLS       = 1,
  parameter int ZERO_REG_EXEMPT = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             Delay,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             pipe_stall,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LU_INIT  = 3'(LU_STALLS - 1);
  localparam bit         LU_MULTI = (LU_STALLS > 1);

  state_t           state_q, state_d;
  state_t           ret_state_q, ret_state_d;
  state_t           act_state_s;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             lu_haz_s, mem_busy_s, act_busy_s;
  logic             rs_match_s, rt_match_s, zero_exempt_s;

  // Hazard detection from the current ID/EX and IF/ID contents
  always_comb begin
    rs_match_s    = IFID_UsesRs && (IFID_Rs == IDEX_Rt);
    rt_match_s    = IFID_UsesRt && (IFID_Rt == IDEX_Rt);
    zero_exempt_s = (ZERO_REG_EXEMPT != 0) && (IDEX_Rt == {REG_W{1'b0}});
    lu_haz_s      = IDEX_MemRead && (rs_match_s || rt_match_s) && !zero_exempt_s;
    mem_busy_s    = mem_req && !mem_ready;
  end

  // Sequencer: on a memory release the rules of the saved state apply with the wait cleared
  always_comb begin
    Delay       = 1'b0;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    pipe_stall  = 1'b0;
    state_d     = state_q;
    ret_state_d = ret_state_q;
    lu_cnt_d    = lu_cnt_q;
    if (state_q == MEM_WAIT) begin
      act_state_s = ret_state_q;
      act_busy_s  = 1'b0;
    end else begin
      act_state_s = state_q;
      act_busy_s  = mem_busy_s;
    end

    if ((state_q == MEM_WAIT) && !mem_ready) begin
      pipe_stall = 1'b1;
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      state_d    = MEM_WAIT;
    end else begin
      case (act_state_s)
        RUN: begin
          if (act_busy_s) begin
            pipe_stall  = 1'b1;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            ret_state_d = RUN;
            state_d     = MEM_WAIT;
          end else if (branch_taken) begin
            IFID_Flush = 1'b1;
            Delay      = 1'b1;
            state_d    = RUN;
          end else if (lu_haz_s) begin
            Delay      = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            if (LU_MULTI) begin
              lu_cnt_d = LU_INIT;
              state_d  = LU_STALL;
            end else begin
              state_d  = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        LU_STALL: begin
          if (act_busy_s) begin
            pipe_stall  = 1'b1;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            ret_state_d = LU_STALL;
            state_d     = MEM_WAIT;
          end else if (branch_taken) begin
            IFID_Flush = 1'b1;
            Delay      = 1'b1;
            lu_cnt_d   = 3'd0;
            state_d    = RUN;
          end else begin
            Delay      = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            if (lu_cnt_q <= 3'd1) begin
              lu_cnt_d = 3'd0;
              state_d  = RUN;
            end else begin
              lu_cnt_d = lu_cnt_q - 3'd1;
              state_d  = LU_STALL;
            end
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // Reset forces a flush-and-hold so nothing advances while the pipe is being cleared
    if (rst) begin
      Delay      = 1'b1;
      IFID_Flush = 1'b1;
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      pipe_stall = 1'b0;
    end else begin
      IFID_Flush = IFID_Flush;
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    if ((Delay || pipe_stall) && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ret_state_q    <= RUN;
      lu_cnt_q       <= 3'd0;
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      lu_cnt_q       <= lu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LU_STALLS=1, LU_STALLS=3, CNT_W=4)
// share one stimulus stream; outputs packed as {Delay,PCWrite,IFID_Write,IFID_Flush,pipe_stall}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mr, urs, urt, br, mreq, mrdy;
  logic [3:0] idex_rt, rs, rt;

  logic        a_dl, a_pc, a_iw, a_fl, a_ps;
  logic        b_dl, b_pc, b_iw, b_fl, b_ps;
  logic        c_dl, c_pc, c_iw, c_fl, c_ps;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;
  logic [4:0]  a_o, b_o, c_o;

  assign a_o = {a_dl, a_pc, a_iw, a_fl, a_ps};
  assign b_o = {b_dl, b_pc, b_iw, b_fl, b_ps};
  assign c_o = {c_dl, c_pc, c_iw, c_fl, c_ps};

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(4), .LU_STALLS(1), .ZERO_REG_EXEMPT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(idex_rt), .IFID_Rs(rs), .IFID_Rt(rt),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .Delay(a_dl), .PCWrite(a_pc), .IFID_Write(a_iw), .IFID_Flush(a_fl), .pipe_stall(a_ps),
    .stall_cycles(a_cnt));

  hazard_ctrl #(.REG_W(4), .LU_STALLS(3), .ZERO_REG_EXEMPT(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(idex_rt), .IFID_Rs(rs), .IFID_Rt(rt),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .Delay(b_dl), .PCWrite(b_pc), .IFID_Write(b_iw), .IFID_Flush(b_fl), .pipe_stall(b_ps),
    .stall_cycles(b_cnt));

  hazard_ctrl #(.REG_W(4), .LU_STALLS(1), .ZERO_REG_EXEMPT(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(idex_rt), .IFID_Rs(rs), .IFID_Rt(rt),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .Delay(c_dl), .PCWrite(c_pc), .IFID_Write(c_iw), .IFID_Flush(c_fl), .pipe_stall(c_ps),
    .stall_cycles(c_cnt));

  typedef struct {
    logic       mr;
    logic [3:0] idex_rt;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  localparam logic [4:0] O_RUN    = 5'b01100;
  localparam logic [4:0] O_BUBBLE = 5'b10000;
  localparam logic [4:0] O_BRANCH = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b10010;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    mr = 1'b0; idex_rt = 4'd0; rs = 4'd0; rt = 4'd0;
    urs = 1'b0; urt = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b0;
  endtask

  task automatic rand_inputs();
    mr = 1'($urandom_range(0, 1)); idex_rt = 4'($urandom_range(0, 15));
    rs = 4'($urandom_range(0, 15)); rt = 4'($urandom_range(0, 15));
    urs = 1'($urandom_range(0, 1)); urt = 1'($urandom_range(0, 1));
    br = 1'($urandom_range(0, 1)); mreq = 1'($urandom_range(0, 1));
    mrdy = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_lu(input logic [3:0] rt_v, input logic [3:0] rs_v);
    idle();
    mr = 1'b1; idex_rt = rt_v; rs = rs_v; urs = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Check dut_b outputs at the falling edge, then advance one cycle
  task automatic cyc_b(input string nm, input logic [4:0] exp);
    @(negedge clk);
    chk(nm, {27'd0, b_o}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_a;
    vecs[0] = '{1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1] = '{1'b1, 4'd5,  4'd5,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_BUBBLE};
    vecs[2] = '{1'b1, 4'd5,  4'd5,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[3] = '{1'b1, 4'd7,  4'd1,  4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BUBBLE};
    vecs[4] = '{1'b0, 4'd7,  4'd7,  4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[5] = '{1'b1, 4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[6] = '{1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[7] = '{1'b1, 4'd3,  4'd3,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[8] = '{1'b1, 4'd9,  4'd9,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_BUBBLE};
    vecs[9] = '{1'b1, 4'd15, 4'd15, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BUBBLE};

    // Reset held two cycles with random inputs
    rst = 1'b1;
    rand_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_out_a%0d", k), {27'd0, a_o}, {27'd0, O_RESET});
      chk($sformatf("rst_out_b%0d", k), {27'd0, b_o}, {27'd0, O_RESET});
      chk($sformatf("rst_out_c%0d", k), {27'd0, c_o}, {27'd0, O_RESET});
      chk($sformatf("rst_cnt_a%0d", k), {16'd0, a_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rand_inputs();
    end
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_a", {27'd0, a_o}, {27'd0, O_RUN});
    chk("post_rst_b", {27'd0, b_o}, {27'd0, O_RUN});
    @(posedge clk);
    #1;
    chk("post_rst_cnt_b", {16'd0, b_cnt}, 32'd0);

    // Table of single-cycle decisions in RUN on the LU_STALLS=1 instance
    do_reset();
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      mr = vecs[i].mr; idex_rt = vecs[i].idex_rt; rs = vecs[i].rs; rt = vecs[i].rt;
      urs = vecs[i].urs; urt = vecs[i].urt; br = vecs[i].br;
      mreq = vecs[i].mreq; mrdy = vecs[i].mrdy;
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), {27'd0, a_o}, {27'd0, vecs[i].exp});
      if (vecs[i].exp[4] || vecs[i].exp[0]) cnt_a++;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), {16'd0, a_cnt}, cnt_a);
    end

    // Load-use: one bubble on dut_a, three on dut_b
    do_reset();
    apply_lu(4'd5, 4'd5);
    @(negedge clk);
    chk("lu1_a_c0", {27'd0, a_o}, {27'd0, O_BUBBLE});
    chk("lu3_b_c0", {27'd0, b_o}, {27'd0, O_BUBBLE});
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("lu1_a_c1", {27'd0, a_o}, {27'd0, O_RUN});
    chk("lu3_b_c1", {27'd0, b_o}, {27'd0, O_BUBBLE});
    @(posedge clk);
    #1;
    cyc_b("lu3_b_c2", O_BUBBLE);
    cyc_b("lu3_b_c3", O_RUN);
    chk("lu1_cnt_a", {16'd0, a_cnt}, 32'd1);
    chk("lu3_cnt_b", {16'd0, b_cnt}, 32'd3);

    // Register-0 dependency is exempt
    do_reset();
    apply_lu(4'd0, 4'd0);
    cyc_b("zero_exempt", O_RUN);
    idle();
    cyc_b("zero_exempt_next", O_RUN);
    chk("zero_exempt_cnt", {16'd0, b_cnt}, 32'd0);

    // Branch and load-use together: flush only, no follow-on stall
    do_reset();
    apply_lu(4'd5, 4'd5);
    br = 1'b1;
    cyc_b("br_lu_c0", O_BRANCH);
    idle();
    cyc_b("br_lu_c1", O_RUN);
    cyc_b("br_lu_c2", O_RUN);
    chk("br_lu_cnt", {16'd0, b_cnt}, 32'd1);

    // Memory wait at the second bubble of a 3-bubble stall
    do_reset();
    apply_lu(4'd5, 4'd5);
    cyc_b("mw_c0", O_BUBBLE);
    idle();
    mreq = 1'b1;
    cyc_b("mw_freeze0", O_FREEZE);
    br = 1'b1;
    cyc_b("mw_freeze1", O_FREEZE);
    cyc_b("mw_freeze2", O_FREEZE);
    cyc_b("mw_freeze3", O_FREEZE);
    br = 1'b0;
    mrdy = 1'b1;
    cyc_b("mw_release", O_BUBBLE);
    idle();
    cyc_b("mw_last", O_BUBBLE);
    cyc_b("mw_run", O_RUN);
    chk("mw_cnt", {16'd0, b_cnt}, 32'd7);

    // Reset in the middle of a memory freeze
    do_reset();
    mreq = 1'b1;
    cyc_b("rmw_f0", O_FREEZE);
    cyc_b("rmw_f1", O_FREEZE);
    rst = 1'b1;
    cyc_b("rmw_rst", O_RESET);
    rst = 1'b0;
    idle();
    cyc_b("rmw_run", O_RUN);
    chk("rmw_cnt", {16'd0, b_cnt}, 32'd0);

    // Counter saturation with a 20-cycle freeze
    do_reset();
    mreq = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt_c", {28'd0, c_cnt}, 32'd15);
    chk("sat_cnt_a", {16'd0, a_cnt}, 32'd20);
    idle();
    mrdy = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_hold_c", {28'd0, c_cnt}, 32'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage datapath. It generates the Delay select that makes the ID/EX control mux inject a bubble, plus PC and IF/ID write enables and the IF/ID flush. It handles three cases: load-use stalls (configurable length), taken-branch flushes, and multi-cycle data-memory waits (whole-pipe freeze with resume-to-prior-state). It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_W, 4, register-specifier width.
LU_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..7.
ZERO_REG_EXEMPT, 1, when 1 a dependency on register 0 is never a hazard.
CNT_W, 16, width of stall_cycles.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
IDEX_MemRead  in  1  instruction in EX is a load.
IDEX_Rt  in  REG_W  destination register of the load in EX.
IFID_Rs  in  REG_W  source register 1 of the instruction in ID.
IFID_Rt  in  REG_W  source register 2 of the instruction in ID.
IFID_UsesRs  in  1  ID instruction reads Rs.
IFID_UsesRt  in  1  ID instruction reads Rt.
branch_taken  in  1  branch in EX resolved taken this cycle.
mem_req  in  1  MEM stage has an access in flight.
mem_ready  in  1  memory completes the access this cycle.
Delay  out  1  to ID/EX control mux; 1 = zero all control (bubble).
PCWrite  out  1  PC load enable.
IFID_Write  out  1  IF/ID register load enable.
IFID_Flush  out  1  clear IF/ID to NOP at next edge.
pipe_stall  out  1  freeze ID/EX, EX/MEM and MEM/WB (hold, no bubble).
stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Registers: lu_cnt (3 bits) and ret_state (RUN or LU_STALL).
- Outputs are combinational from state and inputs (Mealy). The defaults are Delay=0, PCWrite=1, IFID_Write=1, IFID_Flush=0, pipe_stall=0.
- The load-use hazard lu_haz is true when both of the following hold:
  - IDEX_MemRead=1.
  - (IFID_UsesRs and IFID_Rs==IDEX_Rt) or (IFID_UsesRt and IFID_Rt==IDEX_Rt).
  - Exception: lu_haz is forced to 0 when ZERO_REG_EXEMPT=1 and IDEX_Rt==0.
- mem_busy = mem_req and not mem_ready.
- Priority in RUN: mem_busy, then branch_taken, then lu_haz.
  - mem_busy: pipe_stall=1, PCWrite=0, IFID_Write=0, Delay=0. ret_state<=RUN; next state MEM_WAIT.
  - branch_taken: IFID_Flush=1, Delay=1, PCWrite=1. Stay in RUN. Any simultaneous lu_haz is ignored, because the flushed instruction is the wrong path.
  - lu_haz: Delay=1, PCWrite=0, IFID_Write=0. If LU_STALLS==1, stay in RUN. Otherwise lu_cnt<=LU_STALLS-1 and next state LU_STALL.
- LU_STALL:
  - Outputs: Delay=1, PCWrite=0, IFID_Write=0.
  - lu_cnt decrements each cycle; when lu_cnt==1, next state RUN.
  - branch_taken aborts the stall with the RUN branch outputs and next state RUN.
  - mem_busy takes precedence over both: freeze outputs as in RUN, lu_cnt holds, ret_state<=LU_STALL, next state MEM_WAIT.
- MEM_WAIT:
  - While mem_ready=0: freeze outputs (pipe_stall=1, PCWrite=0, IFID_Write=0, Delay=0, IFID_Flush=0). branch_taken and lu_haz are ignored.
  - Release cycle (mem_ready=1): outputs are evaluated exactly as in ret_state with mem_busy treated as 0. The next state is the one ret_state's rules produce.
- Total bubbles per load-use hazard with no interference = LU_STALLS, counted on consecutive cycles with Delay=1 excluding frozen cycles.
- stall_cycles increments by 1 on every cycle where Delay=1 or pipe_stall=1, excluding cycles with rst=1. It saturates at all-ones and does not wrap.
- Reset (rst=1 at a clock edge): state<=RUN, lu_cnt<=0, ret_state<=RUN, stall_cycles<=0.
  - While rst=1, outputs are forced: Delay=1, IFID_Flush=1, PCWrite=0, IFID_Write=0, pipe_stall=0.
  - Reset mid-LU_STALL or mid-MEM_WAIT abandons the sequence; the first cycle after rst deasserts is RUN.
- No X on any output after the first reset edge. Unused inputs in a given state must not affect outputs.

Test Plan:
- Reset: hold rst 2 cycles with all inputs random → Delay=1, IFID_Flush=1, PCWrite=0, pipe_stall=0, stall_cycles=0. First cycle after release with no hazards → PCWrite=1, IFID_Write=1, Delay=0.
- Load-use, LU_STALLS=1 and LU_STALLS=3: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5, IFID_UsesRs=1 → exactly 1 (resp. 3) cycles Delay=1, PCWrite=0; then RUN. stall_cycles=1 (resp. 3). Same stimulus with IDEX_Rt=0, ZERO_REG_EXEMPT=1 → no stall.
- Branch vs load-use same cycle: branch_taken=1 with lu_haz true → IFID_Flush=1, Delay=1, PCWrite=1 for one cycle; no subsequent stall.
- Memory wait inside load-use stall (LU_STALLS=3): mem_req=1, mem_ready=0 for 4 cycles at the 2nd bubble → pipe_stall=1 for 4 cycles with Delay=0. After mem_ready, remaining bubbles = 2, then RUN.
- Reset mid-MEM_WAIT: assert rst during a freeze → next post-reset cycle is RUN, pipe_stall=0, stall_cycles=0.
- Counter saturation (CNT_W=4): 20 consecutive stall cycles → stall_cycles holds 15.
